i2s_multi_rx: RTL and testbench

I2S_MULTI_RX -- requirements
Module: i2s_multi_rx

---
 rtl/i2s_pkg.sv | 21 ++
 rtl/i2s_sync.sv | 47 ++++
 rtl/i2s_multi_rx.sv | 201 ++++++++++++++++++++
 tb/tb_i2s_multi_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared types and constants for the multi-line I2S receiver:
//               framing state enum, framing-loss timeout and default width.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

  // sck rises allowed without a ws change before framing is declared lost
  localparam int TIMEOUT_RISES  = 64;
  localparam int DEFAULT_DATA_W = 16;

endpackage
`default_nettype wire

// File: rtl/i2s_sync.sv
`default_nettype none
// ============================================================================
// Module      : i2s_sync
// Description : Multi-stage synchronizer for sck, ws and all sd lines (equal
//               delay on every bit) plus a single-cycle sck rising-edge flag.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_sync #(
  parameter int NUM_LINES   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_sck,
  input  logic                 i_ws,
  input  logic [NUM_LINES-1:0] i_sd,
  output logic                 o_ws,
  output logic [NUM_LINES-1:0] o_sd,
  output logic                 o_sck_rise
);

  // Bit layout of each stage: {sck, ws, sd[NUM_LINES-1:0]}
  localparam int W = NUM_LINES + 2;

  logic [W-1:0] r_sync [SYNC_STAGES];
  logic         r_sck_prev;
  logic [W-1:0] w_last;

  // Shift all serial inputs through the same chain so they stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_sck_prev <= 1'b0;
    end else begin
      r_sync[0] <= {i_sck, i_ws, i_sd};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_sck_prev <= r_sync[SYNC_STAGES-1][W-1];
    end
  end

  assign w_last     = r_sync[SYNC_STAGES-1];
  assign o_sck_rise = w_last[W-1] & ~r_sck_prev;
  assign o_ws       = w_last[W-2];
  assign o_sd       = w_last[NUM_LINES-1:0];

endmodule
`default_nettype wire

// File: rtl/i2s_multi_rx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_multi_rx
// Description : Multi-line I2S receiver. Aligns to ws, captures the first
//               DATA_W bits of each slot MSB-first (zero-filled if the slot
//               is shorter) and presents L/R frames on a valid/ready port
//               with drop-on-full overflow reporting.
//               Optional: I2S_RX_STATUS_EN adds the ovf_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_multi_rx
  import i2s_pkg::*;
#(
  parameter int NUM_LINES   = 2,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        sck,
  input  logic                        ws,
  input  logic [NUM_LINES-1:0]        sd,
  output logic [NUM_LINES*DATA_W-1:0] data_left,
  output logic [NUM_LINES*DATA_W-1:0] data_right,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overflow
`ifdef I2S_RX_STATUS_EN
  ,
  output logic [15:0]                 ovf_count
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT_RISES + 1);
  localparam int LW    = NUM_LINES * DATA_W;

  logic                 w_ws;
  logic                 w_rise;
  logic [NUM_LINES-1:0] w_sd;

  i2s_state_t           r_state;
  i2s_state_t           w_state_next;
  logic                 r_ws_prev;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [TO_W-1:0]      r_to_cnt;
  logic [LW-1:0]        r_shift;
  logic [LW-1:0]        r_left_hold;
  logic [LW-1:0]        w_shift_next;
  logic [LW-1:0]        w_word_fill;
  logic                 w_ws_change;
  logic                 w_timeout;
  logic                 w_slot_end_l;
  logic                 w_complete;

  logic [LW-1:0]        r_data_left;
  logic [LW-1:0]        r_data_right;
  logic                 r_out_valid;
  logic                 r_overflow;

  i2s_sync #(
    .NUM_LINES   (NUM_LINES),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (CLOCK_50),
    .rst        (reset),
    .i_sck      (sck),
    .i_ws       (ws),
    .i_sd       (sd),
    .o_ws       (w_ws),
    .o_sd       (w_sd),
    .o_sck_rise (w_rise)
  );

  // ws edges and framing loss are only meaningful on an sck rise
  assign w_ws_change = w_rise & (w_ws != r_ws_prev);
  assign w_timeout   = w_rise & ~w_ws_change &
                       (r_to_cnt == TO_W'(TIMEOUT_RISES - 1));

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= ALIGN;
    else       r_state <= w_state_next;
  end

  // Next-state and slot-boundary strobes; in LEFT a change is always 0->1,
  // in RIGHT always 1->0, because r_ws_prev tracks every sampled ws
  always_comb begin
    w_state_next = r_state;
    w_slot_end_l = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      ALIGN: begin
        if (w_ws_change && !w_ws) w_state_next = LEFT;
      end
      LEFT: begin
        if (w_timeout) begin
          w_state_next = ALIGN;
        end else if (w_ws_change) begin
          w_state_next = RIGHT;
          w_slot_end_l = 1'b1;
        end
      end
      RIGHT: begin
        if (w_timeout) begin
          w_state_next = ALIGN;
        end else if (w_ws_change) begin
          w_state_next = LEFT;
          w_complete   = 1'b1;
        end
      end
      default: w_state_next = ALIGN;
    endcase
  end

  // Shift in the current bit while fewer than DATA_W bits are held, then
  // left-justify so a short slot ends up zero-filled in its LSBs
  always_comb begin
    w_cnt_next   = (r_cnt < CNT_W'(DATA_W)) ? r_cnt + 1'b1 : r_cnt;
    w_shift_next = r_shift;
    w_word_fill  = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      if (r_cnt < CNT_W'(DATA_W))
        w_shift_next[k*DATA_W +: DATA_W] = {r_shift[k*DATA_W +: DATA_W-1], w_sd[k]};
      w_word_fill[k*DATA_W +: DATA_W] =
        w_shift_next[k*DATA_W +: DATA_W] << (CNT_W'(DATA_W) - w_cnt_next);
    end
  end

  // Bit capture, per-slot counters and the internal left-word latch
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_ws_prev   <= 1'b0;
      r_cnt       <= '0;
      r_to_cnt    <= '0;
      r_shift     <= '0;
      r_left_hold <= '0;
    end else if (w_rise) begin
      r_ws_prev <= w_ws;
      if (r_state == ALIGN || w_ws_change || w_timeout)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + 1'b1;
      // The bit on a ws-change rise belongs to the old slot; the new slot
      // starts empty on the following rise
      if (r_state == ALIGN || w_ws_change || w_timeout) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else begin
        r_cnt   <= w_cnt_next;
        r_shift <= w_shift_next;
      end
      if (w_slot_end_l) r_left_hold <= w_word_fill;
    end
  end

  // Output holding register: load when empty or being drained, else drop
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_data_left  <= '0;
      r_data_right <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_complete) begin
        if (!r_out_valid || out_ready) begin
          r_data_left  <= r_left_hold;
          r_data_right <= w_word_fill;
          r_out_valid  <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign data_left  = r_data_left;
  assign data_right = r_data_right;
  assign out_valid  = r_out_valid;
  assign overflow   = r_overflow;

`ifdef I2S_RX_STATUS_EN
  logic [15:0] r_ovf_count;

  // Saturating count of dropped frames
  always_ff @(posedge CLOCK_50) begin
    if (reset)
      r_ovf_count <= '0;
    else if (r_overflow && r_ovf_count != 16'hFFFF)
      r_ovf_count <= r_ovf_count + 16'd1;
  end

  assign ovf_count = r_ovf_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2s_multi_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_multi_rx
// Description : Directed self-checking bench for i2s_multi_rx (16- and 24-bit
//               instances sharing one I2S bus). Honours I2S_RX_STATUS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_multi_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        sck;
  logic        ws;
  logic [1:0]  sd;
  logic        out_ready;

  logic [31:0] dl16, dr16;
  logic        v16, ovf16;
  logic [47:0] dl24, dr24;
  logic        v24, ovf24;
`ifdef I2S_RX_STATUS_EN
  logic [15:0] cnt16, cnt24;
`endif

  int          n_cmp = 0;
  int          n_err = 0;

  // monitor state
  int          x16 = 0;
  int          x24 = 0;
  int          ovf16_cnt = 0;
  logic [31:0] cap_l16 = '0, cap_r16 = '0;
  logic [47:0] cap_l24 = '0, cap_r24 = '0;

  always #5 clk = ~clk;

  i2s_multi_rx #(.NUM_LINES(2), .DATA_W(16), .SYNC_STAGES(2)) dut16 (
    .CLOCK_50   (clk),
    .reset      (reset),
    .sck        (sck),
    .ws         (ws),
    .sd         (sd),
    .data_left  (dl16),
    .data_right (dr16),
    .out_valid  (v16),
    .out_ready  (out_ready),
    .overflow   (ovf16)
`ifdef I2S_RX_STATUS_EN
    ,
    .ovf_count  (cnt16)
`endif
  );

  i2s_multi_rx #(.NUM_LINES(2), .DATA_W(24), .SYNC_STAGES(3)) dut24 (
    .CLOCK_50   (clk),
    .reset      (reset),
    .sck        (sck),
    .ws         (ws),
    .sd         (sd),
    .data_left  (dl24),
    .data_right (dr24),
    .out_valid  (v24),
    .out_ready  (out_ready),
    .overflow   (ovf24)
`ifdef I2S_RX_STATUS_EN
    ,
    .ovf_count  (cnt24)
`endif
  );

  // Record every accepted frame and every overflow pulse
  always @(negedge clk) begin
    if (v16 && out_ready) begin
      x16     <= x16 + 1;
      cap_l16 <= dl16;
      cap_r16 <= dr16;
    end
    if (v24 && out_ready) begin
      x24     <= x24 + 1;
      cap_l24 <= dl24;
      cap_r24 <= dr24;
    end
    if (ovf16) ovf16_cnt <= ovf16_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // One I2S bit period: data and ws change on the falling sck edge
  task automatic sck_bit(input logic w, input logic [1:0] d);
    ws  = w;
    sd  = d;
    #40 sck = 1'b1;
    #40 sck = 1'b0;
  endtask

  // Full frame of n-bit slots, words left-justified in 32 bits; ws leads
  // the MSB by one bit, so the last bit of each slot carries the new ws
  task automatic send_frame(input logic [31:0] l0, input logic [31:0] r0,
                            input logic [31:0] l1, input logic [31:0] r1,
                            input int n);
    logic [31:0] a, b;
    a = l0; b = l1;
    for (int i = 0; i < n; i++) begin
      sck_bit(i == n - 1, {b[31], a[31]});
      a = a << 1; b = b << 1;
    end
    a = r0; b = r1;
    for (int i = 0; i < n; i++) begin
      sck_bit(i != n - 1, {b[31], a[31]});
      a = a << 1; b = b << 1;
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 out_ready = r;
  endtask

  int base;

  initial begin
    reset = 1'b1; sck = 1'b0; ws = 1'b0; sd = 2'b00; out_ready = 1'b1;
    #2;
    wait_clk(5);
    chk("rst_valid", v16, 1'b0);
    chk("rst_left",  dl16, 32'h0);
    chk("rst_right", dr16, 32'h0);
    chk("rst_ovf",   ovf16, 1'b0);
`ifdef I2S_RX_STATUS_EN
    chk("rst_ovfcnt", cnt16, 16'h0);
`endif
    @(posedge clk); #1 reset = 1'b0;
    #1;

    // Align: one right-slot tail bit, then the 1->0 change
    sck_bit(1'b1, 2'b11);
    sck_bit(1'b0, 2'b00);

    // Basic frame with junk beyond bit 16 that must be ignored
    send_frame({16'hA5A5, 16'h5A5A}, {16'h1234, 16'hFFFF},
               {16'h8001, 16'h7777}, {16'h7FFE, 16'h0001}, 32);
    wait_clk(10);
    chk("fA_count", x16, 1);
    chk("fA_left",  cap_l16, {16'h8001, 16'hA5A5});
    chk("fA_right", cap_r16, {16'h7FFE, 16'h1234});
    chk("fA_vlow",  v16, 1'b0);

    send_frame({16'hFFFF, 16'h0000}, {16'h0001, 16'hFFFF},
               {16'h0000, 16'hFFFF}, {16'h8000, 16'h0000}, 32);
    wait_clk(10);
    chk("fB_count", x16, 2);
    chk("fB_left",  cap_l16, {16'h0000, 16'hFFFF});
    chk("fB_right", cap_r16, {16'h8000, 16'h0001});

    // Back-pressure: three frames, first one held, two dropped
    set_ready(1'b0);
    base = x16;
    send_frame({16'h1111, 16'h0}, {16'h2222, 16'h0}, {16'h3333, 16'h0}, {16'h4444, 16'h0}, 32);
    send_frame({16'h5555, 16'h0}, {16'h6666, 16'h0}, {16'h7777, 16'h0}, {16'h8888, 16'h0}, 32);
    send_frame({16'h9999, 16'h0}, {16'hAAAA, 16'h0}, {16'hBBBB, 16'h0}, {16'hCCCC, 16'h0}, 32);
    wait_clk(10);
    chk("bp_ovf_pulses", ovf16_cnt, 2);
    chk("bp_valid",      v16, 1'b1);
    chk("bp_held_left",  dl16, {16'h3333, 16'h1111});
    chk("bp_held_right", dr16, {16'h4444, 16'h2222});
    chk("bp_no_xfer",    x16, base);
`ifdef I2S_RX_STATUS_EN
    chk("bp_ovfcnt",     cnt16, 16'd2);
`endif
    set_ready(1'b1);
    wait_clk(3);
    chk("bp_drain_count", x16, base + 1);
    chk("bp_drain_left",  cap_l16, {16'h3333, 16'h1111});
    chk("bp_drain_vlow",  v16, 1'b0);

    // 16-bit slots: exact fit at 16, zero-filled at 24
    base = x24;
    send_frame({16'hBEEF, 16'h0}, {16'hCAFE, 16'h0}, {16'h1357, 16'h0}, {16'h2468, 16'h0}, 16);
    wait_clk(10);
    chk("s16_left16",  cap_l16, {16'h1357, 16'hBEEF});
    chk("s16_right16", cap_r16, {16'h2468, 16'hCAFE});
    chk("s16_count24", x24, base + 1);
    chk("s16_left24",  cap_l24, {24'h135700, 24'hBEEF00});
    chk("s16_right24", cap_r24, {24'h246800, 24'hCAFE00});

    // Reset in the middle of a left slot
    repeat (5) sck_bit(1'b0, 2'b11);
    @(posedge clk); #1 reset = 1'b1;
    wait_clk(3);
    chk("mid_rst_valid", v16, 1'b0);
    chk("mid_rst_left",  dl16, 32'h0);
    chk("mid_rst_right", dr16, 32'h0);
    chk("mid_rst_ovf",   ovf16, 1'b0);
`ifdef I2S_RX_STATUS_EN
    chk("mid_rst_ovfcnt", cnt16, 16'h0);
`endif
    @(posedge clk); #1 reset = 1'b0;
    #1;

    // Start mid-right-slot: the tail and its 1->0 change must not emit
    base = x16;
    repeat (7) sck_bit(1'b1, 2'b10);
    sck_bit(1'b0, 2'b01);
    wait_clk(10);
    chk("midR_no_frame", x16, base);
    send_frame({16'h0F0F, 16'h1234}, {16'hF0F0, 16'h0}, {16'h3C3C, 16'h0}, {16'hC3C3, 16'h0}, 32);
    wait_clk(10);
    chk("midR_count", x16, base + 1);
    chk("midR_left",  cap_l16, {16'h3C3C, 16'h0F0F});
    chk("midR_right", cap_r16, {16'hC3C3, 16'hF0F0});

    // Framing loss: 100 periods with ws stuck, then realign on the next frame
    base = x16;
    repeat (100) sck_bit(1'b0, 2'b10);
    send_frame({16'hDEAD, 16'h0}, {16'hBEEF, 16'h0}, {16'hFACE, 16'h0}, {16'hB00C, 16'h0}, 32);
    wait_clk(10);
    chk("to_align_frame", x16, base);
    send_frame({16'h6789, 16'h0}, {16'h9876, 16'h0}, {16'h0123, 16'h0}, {16'h3210, 16'h0}, 32);
    wait_clk(10);
    chk("to_count", x16, base + 1);
    chk("to_left",  cap_l16, {16'h0123, 16'h6789});
    chk("to_right", cap_r16, {16'h3210, 16'h9876});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
